// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - handshake and operand/result bundle for muldiv_unit
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, b, mthi, mtlo,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] a_orig;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             done_r;

  // Signed ops work on magnitudes; signs are reapplied in FIX.
  logic             signed_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign signed_op = ~bus.op[0];
  assign a_neg     = signed_op & bus.a[WIDTH-1];
  assign b_neg     = signed_op & bus.b[WIDTH-1];
  assign a_mag     = a_neg ? (~bus.a + 1'b1) : bus.a;
  assign b_mag     = b_neg ? (~bus.b + 1'b1) : bus.b;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_fits;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign mul_sum   = {1'b0, acc} + (mq[0] ? {1'b0, mag_b} : {(WIDTH+1){1'b0}});
  assign div_shift = {acc, mq[WIDTH-1]};
  assign div_fits  = div_shift >= {1'b0, mag_b};
  assign div_rem   = div_shift[WIDTH-1:0] - mag_b;
  assign prod_fix  = neg_q ? (~{acc, mq} + 1'b1) : {acc, mq};
  assign quot_fix  = neg_q ? (~mq + 1'b1) : mq;
  assign rem_fix   = neg_r ? (~acc + 1'b1) : acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (cnt == CW'(WIDTH-1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      mag_b    <= '0;
      acc      <= '0;
      mq       <= '0;
      a_orig   <= '0;
      hi_r     <= '0;
      lo_r     <= '0;
      done_r   <= 1'b0;
    end else begin
      done_r <= (state == FIX);
      case (state)
        IDLE: begin
          if (bus.start) begin
            is_div   <= bus.op[1];
            mag_b    <= b_mag;
            mq       <= a_mag;
            acc      <= '0;
            cnt      <= '0;
            a_orig   <= bus.a;
            div_zero <= (bus.b == '0);
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
          end else begin
            if (bus.mthi) hi_r <= bus.a;
            if (bus.mtlo) lo_r <= bus.a;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            acc <= div_fits ? div_rem : div_shift[WIDTH-1:0];
            mq  <= {mq[WIDTH-2:0], div_fits};
          end else begin
            {acc, mq} <= {mul_sum, mq[WIDTH-1:1]};
          end
        end
        FIX: begin
          // Divide by zero leaves the dividend untouched in HI.
          if (is_div && div_zero) begin
            hi_r <= a_orig;
            lo_r <= '1;
          end else if (is_div) begin
            hi_r <= rem_fix;
            lo_r <= quot_fix;
          end else begin
            {hi_r, lo_r} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
  assign bus.busy = (state != IDLE);
  assign bus.done = done_r;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of `registerfile`.
- It consumes the `a`/`b` read-port operands and executes MULT, MULTU, DIV and DIVU over multiple cycles.
- Results go into internal HI/LO registers, which are read by MFHI/MFLO and written by MTHI/MTLO.
- A start/busy/done handshake lets the pipeline control stall while an operation runs.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; the iteration count equals WIDTH.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  launch the operation selected by `op` on `a`/`b`; sampled only when `busy`=0.
- op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  input  WIDTH  operand rs, from `registerfile` port `a`; multiplicand or dividend; also the MTHI/MTLO data.
- b  input  WIDTH  operand rt, from `registerfile` port `b`; multiplier or divisor.
- mthi  input  1  write `a` into HI.
- mtlo  input  1  write `a` into LO.
- hi  output  WIDTH  HI register; high product half or remainder.
- lo  output  WIDTH  LO register; low product half or quotient.
- busy  output  1  an operation is in progress; new starts and MTHI/MTLO are ignored.
- done  output  1  one-cycle pulse when `hi`/`lo` take a new operation result.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - `hi`=0, `lo`=0, `busy`=0, `done`=0, FSM to IDLE.
  - Any in-flight operation is discarded.
- FSM states: IDLE, RUN, FIX.
  - IDLE: on an edge with `start`=1, latch `op`, `a`, `b`.
    - For signed ops, latch magnitudes plus the result-sign flags.
    - Clear the partial accumulator, iteration counter := 0, go to RUN, `busy`=1.
  - RUN: one iteration per edge.
    - Multiply: shift-add.
    - Divide: restoring, one quotient bit per cycle.
    - After WIDTH iterations (counter = WIDTH-1 at the edge), go to FIX.
  - FIX: apply sign correction, load `hi`/`lo`, `done`=1 for this cycle only, `busy`=0, go to IDLE.
- Timing:
  - Latency: with `start` sampled at edge E0, `hi`/`lo` update and `done` rises at edge E(WIDTH+1), which is E33 by default.
  - `busy` is high after E0 through E(WIDTH+1); it deasserts at the same edge `done` asserts.
  - `hi`/`lo` hold their previous values throughout RUN and change only in FIX or on MTHI/MTLO.
- Handshake and write priority:
  - `start`, `mthi` and `mtlo` are ignored while `busy`=1; a held `start` does not queue.
  - A new `start` may be accepted on the edge right after `done`, back-to-back.
  - IDLE with `start`=1 and `mthi`/`mtlo`=1 on the same edge: `start` wins, the move is ignored.
  - `mthi` and `mtlo` together in IDLE: both registers load `a`.
  - A move updates its register at the next edge; `done` is not asserted for moves.
- Arithmetic (WIDTH=32):
  - MULT: {hi,lo} = signed 64-bit product.
  - MULTU: {hi,lo} = unsigned 64-bit product.
  - DIVU: lo = a/b, hi = a%b.
  - DIV: quotient truncated toward zero, negative iff operand signs differ; remainder takes the sign of the dividend.
- Boundaries:
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wrap, no exception).
  - Divide by zero (DIV or DIVU), full latency: lo=0xFFFFFFFF, hi=a unmodified (sign fix bypassed).
  - Operand 0 in a multiply: result 0, full latency (no early-out).
  - `a`/`b` may change after E0 without affecting the result.

Test Plan:
- Reset then idle: hi=0, lo=0, busy=0, done=0; mthi with a=0x12345678 -> hi=0x12345678 next edge; mtlo with a=0xCAFEBABE -> lo=0xCAFEBABE.
- MULT a=0xFFFFFFFD (-3), b=5 -> done exactly 33 edges after start; hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=100, b=0 -> done after 33 edges; lo=0xFFFFFFFF, hi=100.
- During busy: change a/b, assert start with op=MULTU, assert mthi -> result is the original operation's; no second op; hi untouched by mthi. Then start on the edge after done -> accepted.
- MULTU a=6, b=7 started; rst pulsed asynchronously mid-cycle at iteration 10 -> busy, hi, lo drop to 0 immediately; no done pulse follows; a fresh start completes normally with lo=42.
